// File: rtl/kyber_pkg.sv
// ============================================================================
// Package  : kyber_pkg
// Brief    : Shared Baby Kyber constants, coefficient/tag types and sampler
//            helper functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kyber_pkg;

    localparam int N          = 4;
    localparam int K          = 2;
    localparam int Q          = 17;
    localparam int ETA        = 2;
    localparam int RW         = 6;
    localparam int FIFO_DEPTH = 4;

    localparam int CW = $clog2(Q);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (K > 1) ? $clog2(K) : 1;

    typedef logic [CW-1:0]        coeff_t;
    typedef logic signed [RW-1:0] raw_t;

    typedef struct packed {
        coeff_t          data;
        logic [IW-1:0]   idx;
        logic [PW-1:0]   poly;
        logic            last;
        logic            vec_last;
    } sample_tag_t;

    localparam int TAG_W = $bits(sample_tag_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_FLUSH  = 2'd2
    } sampler_state_t;

    localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);
    localparam logic [PW-1:0] POLY_MAX = PW'(K - 1);

    localparam raw_t ETA_POS = raw_t'(ETA);
    localparam raw_t ETA_NEG = raw_t'(-ETA);

    localparam logic signed [RW:0] Q_EXT = $signed(Q[RW:0]);

    function automatic logic in_range(input raw_t x);
        return (x >= ETA_NEG) && (x <= ETA_POS);
    endfunction

    // Negative samples wrap to x + Q; the sum fits in RW+1 signed bits.
    function automatic coeff_t map_coeff(input raw_t x);
        logic signed [RW:0] w_ext;
        logic signed [RW:0] w_sum;
        w_ext = {x[RW-1], x};
        w_sum = x[RW-1] ? (w_ext + Q_EXT) : w_ext;
        return w_sum[CW-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/noise_poly_sampler_if.sv
// ============================================================================
// Interface : noise_poly_sampler_if
// Brief     : Raw random-word input stream and tagged coefficient output stream.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface noise_poly_sampler_if;
    import kyber_pkg::*;

    raw_t            rnd_data;
    logic            rnd_valid;
    logic            rnd_ready;

    coeff_t          coeff_data;
    logic [IW-1:0]   coeff_idx;
    logic [PW-1:0]   coeff_poly;
    logic            coeff_last;
    logic            vec_last;
    logic            coeff_valid;
    logic            coeff_ready;

    modport master (
        input  rnd_data, rnd_valid, coeff_ready,
        output rnd_ready, coeff_data, coeff_idx, coeff_poly,
               coeff_last, vec_last, coeff_valid
    );

    modport slave (
        output rnd_data, rnd_valid, coeff_ready,
        input  rnd_ready, coeff_data, coeff_idx, coeff_poly,
               coeff_last, vec_last, coeff_valid
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with count-based full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: empty masks the head until it is written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/noise_poly_sampler.sv
// ============================================================================
// Module   : noise_poly_sampler
// Brief    : Rejection-samples raw signed words into [-ETA, ETA], maps them mod
//            Q and streams a K x N noise vector as tagged coefficients.
// Options  : SAMPLER_STATS_EN adds the reject_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noise_poly_sampler
    import kyber_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    noise_poly_sampler_if.master  bus,
    output logic                  busy,
    output logic                  done
`ifdef SAMPLER_STATS_EN
    ,
    output logic [15:0]           reject_cnt
`endif
);

    sampler_state_t  r_state;
    logic [IW-1:0]   r_idx;
    logic [PW-1:0]   r_poly;
    logic            r_busy;
    logic            r_done;

    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_xfer;
    logic            w_in_range;
    logic            w_accept;
    logic            w_idx_last;
    logic            w_poly_last;
    logic            w_pop;
    sample_tag_t     w_push_tag;
    sample_tag_t     w_head;
    sample_tag_t     w_out;

    assign bus.rnd_ready = (r_state == ST_SAMPLE) && !w_fifo_full;
    assign w_xfer        = bus.rnd_valid && bus.rnd_ready;
    assign w_in_range    = in_range(bus.rnd_data);
    assign w_accept      = w_xfer && w_in_range;
    assign w_idx_last    = (r_idx == IDX_MAX);
    assign w_poly_last   = (r_poly == POLY_MAX);

    assign w_push_tag.data     = map_coeff(bus.rnd_data);
    assign w_push_tag.idx      = r_idx;
    assign w_push_tag.poly     = r_poly;
    assign w_push_tag.last     = w_idx_last;
    assign w_push_tag.vec_last = w_idx_last && w_poly_last;

    assign w_pop = !w_fifo_empty && bus.coeff_ready;

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_wdata (w_push_tag),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Fields read as zero whenever no beat is offered.
    assign w_out           = w_fifo_empty ? '0 : w_head;
    assign bus.coeff_valid = !w_fifo_empty;
    assign bus.coeff_data  = w_out.data;
    assign bus.coeff_idx   = w_out.idx;
    assign bus.coeff_poly  = w_out.poly;
    assign bus.coeff_last  = w_out.last;
    assign bus.vec_last    = w_out.vec_last;

    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_poly  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SAMPLE;
                        r_idx   <= '0;
                        r_poly  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (w_accept) begin
                        if (w_idx_last) begin
                            r_idx  <= '0;
                            r_poly <= w_poly_last ? '0 : (r_poly + 1'b1);
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                        end
                        if (w_idx_last && w_poly_last) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_fifo_empty) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAMPLER_STATS_EN
    logic        w_reject;
    logic [15:0] r_reject_cnt;

    assign w_reject   = w_xfer && !w_in_range;
    assign reject_cnt = r_reject_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reject_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_reject_cnt <= '0;
        end else if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
            r_reject_cnt <= r_reject_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noise_poly_sampler.sv
// ============================================================================
// Module   : tb_noise_poly_sampler
// Brief    : Self-checking bench for noise_poly_sampler (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_noise_poly_sampler;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef SAMPLER_STATS_EN
    logic [15:0] reject_cnt;
`endif

    noise_poly_sampler_if bus();

    noise_poly_sampler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
`ifdef SAMPLER_STATS_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    // kind: 0 = rejected, 1 = accepted, 2 = must not be consumed
    typedef struct {
        raw_t   x;
        int     kind;
        coeff_t coeff;
    } vec_t;

    vec_t        tbl [12];
    sample_tag_t sb_q [$];
    sample_tag_t mon_exp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          beat_cnt = 0;
    int          e_cnt = 0;
    int          rej_exp = 0;
    bit          rand_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_acc(input raw_t x);
        int v;
        v = x;
        return (v >= -ETA) && (v <= ETA);
    endfunction

    function automatic coeff_t ref_map(input raw_t x);
        int v;
        v = x;
        if (v < 0) v = v + Q;
        return coeff_t'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_expected(input coeff_t c);
        sample_tag_t t;
        t.data     = c;
        t.idx      = IW'(e_cnt % N);
        t.poly     = PW'(e_cnt / N);
        t.last     = ((e_cnt % N) == N - 1);
        t.vec_last = (e_cnt == K * N - 1);
        sb_q.push_back(t);
        e_cnt++;
    endtask

    task automatic send_word(input raw_t x, input bit acc, input coeff_t c);
        bit ok;
        ok = 1'b0;
        bus.rnd_data  = x;
        bus.rnd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rnd_ready) begin
                ok = 1'b1;
                if (acc) push_expected(c);
                else     rej_exp++;
                break;
            end
        end
        tick();
        bus.rnd_valid = 1'b0;
        if (!ok) check("rnd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (bus.coeff_valid && bus.coeff_ready) begin
                    beat_cnt++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        check("coeff_data", bus.coeff_data, mon_exp.data);
                        check("coeff_idx",  bus.coeff_idx,  mon_exp.idx);
                        check("coeff_poly", bus.coeff_poly, mon_exp.poly);
                        check("coeff_last", bus.coeff_last, mon_exp.last);
                        check("vec_last",   bus.vec_last,   mon_exp.vec_last);
                        check("coeff_lt_q", {31'd0, (int'(bus.coeff_data) < Q)}, 32'd1);
                    end
                end
            end
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;
        raw_t w;

        tbl[0]  = '{raw_t'(0),   1, 5'd0};
        tbl[1]  = '{raw_t'(1),   1, 5'd1};
        tbl[2]  = '{raw_t'(-1),  1, 5'd16};
        tbl[3]  = '{raw_t'(2),   1, 5'd2};
        tbl[4]  = '{raw_t'(-2),  1, 5'd15};
        tbl[5]  = '{raw_t'(3),   0, 5'd0};
        tbl[6]  = '{raw_t'(-17), 0, 5'd0};
        tbl[7]  = '{raw_t'(5),   0, 5'd0};
        tbl[8]  = '{raw_t'(1),   1, 5'd1};
        tbl[9]  = '{raw_t'(-1),  1, 5'd16};
        tbl[10] = '{raw_t'(0),   1, 5'd0};
        tbl[11] = '{raw_t'(2),   2, 5'd2};

        bus.rnd_data    = '0;
        bus.rnd_valid   = 1'b0;
        bus.coeff_ready = 1'b0;

        fork
            monitor_loop();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rnd_ready",   bus.rnd_ready,   0);
        check("rst_coeff_valid", bus.coeff_valid, 0);
        check("rst_busy",        busy,            0);
        check("rst_done",        done,            0);
        check("rst_coeff_data",  bus.coeff_data,  0);
        check("rst_coeff_idx",   bus.coeff_idx,   0);
        check("rst_coeff_poly",  bus.coeff_poly,  0);
        check("rst_coeff_last",  bus.coeff_last,  0);
        check("rst_vec_last",    bus.vec_last,    0);
        rst_n = 1'b1;
        tick();

        // Words offered while idle are not consumed
        bus.rnd_data  = raw_t'(1);
        bus.rnd_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_rnd_ready", bus.rnd_ready, 0);
        end
        tick();
        bus.rnd_valid = 1'b0;

        // Table-driven vector
        bus.coeff_ready = 1'b1;
        e_cnt = 0; rej_exp = 0;
        d0 = done_cnt; b0 = beat_cnt;
        do_start();
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].kind == 2) begin
                bus.rnd_data  = tbl[i].x;
                bus.rnd_valid = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("t1_no_consume", bus.rnd_ready, 0);
                end
                tick();
                bus.rnd_valid = 1'b0;
            end else begin
                send_word(tbl[i].x, tbl[i].kind == 1, tbl[i].coeff);
            end
        end
        wait_idle("t1_idle");
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_beats",     beat_cnt - b0, 8);
        check("t1_rejects",   rej_exp, 3);
        check("t1_drained",   sb_q.size(), 0);
`ifdef SAMPLER_STATS_EN
        check("t1_reject_cnt", reject_cnt, 3);
`endif

        // Backpressure: FIFO fills, input stalls, output holds
        bus.coeff_ready = 1'b0;
        e_cnt = 0;
        d0 = done_cnt; b0 = beat_cnt;
        do_start();
        send_word(raw_t'(1),  1'b1, 5'd1);
        send_word(raw_t'(-1), 1'b1, 5'd16);
        send_word(raw_t'(2),  1'b1, 5'd2);
        send_word(raw_t'(-2), 1'b1, 5'd15);
        bus.rnd_data  = raw_t'(0);
        bus.rnd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_stall_ready", bus.rnd_ready,   0);
            check("t2_hold_valid",  bus.coeff_valid, 1);
            check("t2_hold_data",   bus.coeff_data,  5'd1);
            check("t2_hold_idx",    bus.coeff_idx,   0);
        end
        tick();
        bus.coeff_ready = 1'b1;
        send_word(raw_t'(0),  1'b1, 5'd0);
        send_word(raw_t'(1),  1'b1, 5'd1);
        send_word(raw_t'(-2), 1'b1, 5'd15);
        send_word(raw_t'(2),  1'b1, 5'd2);
        wait_idle("t2_idle");
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_beats",     beat_cnt - b0, 8);
        check("t2_drained",   sb_q.size(), 0);

        // start while busy is ignored
        e_cnt = 0;
        d0 = done_cnt;
        do_start();
        send_word(raw_t'(2),  1'b1, 5'd2);
        send_word(raw_t'(-1), 1'b1, 5'd16);
        send_word(raw_t'(0),  1'b1, 5'd0);
        do_start();
        check("t3_busy", busy, 1);
        send_word(raw_t'(1),  1'b1, 5'd1);
        send_word(raw_t'(-2), 1'b1, 5'd15);
        send_word(raw_t'(2),  1'b1, 5'd2);
        send_word(raw_t'(-1), 1'b1, 5'd16);
        send_word(raw_t'(1),  1'b1, 5'd1);
        wait_idle("t3_idle");
        check("t3_done_once", done_cnt - d0, 1);
        check("t3_drained",   sb_q.size(), 0);

        // Reset mid-vector
        bus.coeff_ready = 1'b0;
        e_cnt = 0;
        do_start();
        send_word(raw_t'(2),  1'b1, 5'd2);
        send_word(raw_t'(0),  1'b1, 5'd0);
        send_word(raw_t'(-1), 1'b1, 5'd16);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_valid",     bus.coeff_valid, 0);
        check("t4_rnd_ready", bus.rnd_ready,   0);
        check("t4_busy",      busy,            0);
        check("t4_data",      bus.coeff_data,  0);
        check("t4_poly",      bus.coeff_poly,  0);
        check("t4_idx",       bus.coeff_idx,   0);
        sb_q.delete();
        e_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("t4_no_done", done_cnt - d0, 0);
        bus.coeff_ready = 1'b1;
        d0 = done_cnt;
        do_start();
        send_word(raw_t'(-2), 1'b1, 5'd15);
        send_word(raw_t'(1),  1'b1, 5'd1);
        send_word(raw_t'(4),  1'b0, 5'd0);
        send_word(raw_t'(0),  1'b1, 5'd0);
        send_word(raw_t'(2),  1'b1, 5'd2);
        send_word(raw_t'(-1), 1'b1, 5'd16);
        send_word(raw_t'(-2), 1'b1, 5'd15);
        send_word(raw_t'(1),  1'b1, 5'd1);
        send_word(raw_t'(0),  1'b1, 5'd0);
        wait_idle("t4_idle");
        check("t4_done_once", done_cnt - d0, 1);

        // Randomised handshakes, 1000 vectors
        rand_run = 1'b1;
        fork
            begin : ready_toggler
                while (rand_run) begin
                    tick();
                    bus.coeff_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin : rand_driver
                for (int v = 0; v < 1000; v++) begin
                    e_cnt = 0; rej_exp = 0;
                    d0 = done_cnt;
                    do_start();
                    while (e_cnt < K * N) begin
                        if ($urandom_range(0, 3) == 0) tick();
                        if ($urandom_range(0, 7) == 0) w = raw_t'($urandom);
                        else                           w = raw_t'(int'($urandom_range(0, 6)) - 3);
                        send_word(w, ref_acc(w), ref_map(w));
                    end
                    wait_idle("t5_idle");
                    check("t5_done_once", done_cnt - d0, 1);
`ifdef SAMPLER_STATS_EN
                    check("t5_reject_cnt", reject_cnt, rej_exp);
`endif
                end
                rand_run = 1'b0;
            end
        join
        bus.coeff_ready = 1'b1;
        repeat (4) tick();
        check("t5_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
